mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 i_memop  input  4  from EX_MEM; [2]=memory access, [3]=1 load / 0 store, [1:0]=size: 00 byte signed, 01 half signed, 10 word, 11 byte unsigned (store: 11 treated as byte).
REQ-004 i_addr  input  32  full byte address of the access.
REQ-005 i_storeData  input  32  store data, right-aligned.
REQ-006 i_result  input  32  ALU result for non-memory ops.
REQ-007 i_regDest  input  5  destination register; 0 means no writeback.
REQ-008 d_req  output  1  data-bus request, registered.
REQ-009 d_we  output  1  1=write, valid with d_req.
REQ-010 d_addr  output  30  word address (i_addr[31:2]), registered.
REQ-011 d_sel  output  4  byte lane enables, registered.
REQ-012 d_wdata  output  32  lane-replicated store data, registered.
REQ-013 d_ack  input  1  bus completion, one-cycle pulse.
REQ-014 d_rdata  input  32  read data, valid when d_ack=1.
REQ-015 o_stall  output  1  combinational; holds all upstream stages.
REQ-016 wb_result  output  32  registered writeback value.
REQ-017 wb_regDest  output  5  registered writeback register.
REQ-018 o_alignErr  output  1  registered misalignment flag (only with MEM_ALIGN_CHECK_EN).

Function
REQ-019 FSM states IDLE, BUSY; encoding free.
REQ-020 IDLE, i_memop[2]=0: next edge wb_result<=i_result, wb_regDest<=i_regDest; o_stall=0; latency 1.
REQ-021 IDLE, i_memop[2]=1: o_stall=1; next edge latch d_addr, d_sel, d_wdata, d_we=~i_memop[3], d_req<=1, state<=BUSY, wb_regDest<=0, wb_result<=0.
REQ-022 d_sel: word 1111; half 0011/1100 by i_addr[1]; byte 0001<<i_addr[1:0].
REQ-023 d_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-024 BUSY, d_ack=0: o_stall=1, d_req and bus outputs held, wb outputs bubble (0,0).
REQ-025 BUSY, d_ack=1: o_stall=0; next edge d_req<=0, state<=IDLE; load: wb_result<=extracted lane (sign- or zero-extended per size), wb_regDest<=latched regDest; store: wb_regDest<=0, wb_result<=0.
REQ-026 Memory access latency: 2 cycles minimum (request edge + ack cycle); d_req never asserts back-to-back for two distinct accesses without one IDLE cycle.
REQ-027 d_ack in IDLE ignored, no state change.
REQ-028 Load with i_regDest=0 performs bus access; wb_regDest=0.
REQ-029 Load lane extraction uses latched i_addr[1:0], not live input.

Reset
REQ-030 rst=0: state<=IDLE, d_req=0, d_we=0, d_addr=0, d_sel=0, d_wdata=0, wb_result=0, wb_regDest=0, o_alignErr=0, asynchronously.
REQ-031 rst asserted during BUSY abandons the access; a later d_ack is ignored per REQ-027.
REQ-032 First edge after rst release behaves as IDLE.

Configuration
REQ-033 Macro MEM_ALIGN_CHECK_EN defined: half with i_addr[0]=1 or word with i_addr[1:0]!=0 in IDLE does not request the bus, does not stall; next edge o_alignErr<=1 for one cycle, wb_regDest<=0, wb_result<=0.
REQ-034 Macro undefined: no check; o_alignErr tied 0; misaligned address uses d_sel per REQ-022 with low bits ignored as applicable.

Verification
REQ-035 Non-memory op i_result=0x12345678, regDest=5 -> next edge wb_result=0x12345678, wb_regDest=5, o_stall=0.
REQ-036 LB addr 0x103, ack after 3 wait cycles with d_rdata=0x80FFFFFF -> d_sel=1000, stall 4 cycles, wb_result=0xFFFFFF80.
REQ-037 SH addr 0x202 data 0xABCD -> d_addr=0x80, d_sel=1100, d_wdata=0xABCDABCD, d_we=1, wb_regDest=0.
REQ-038 LW addr 0x10, rst pulsed low in BUSY, then stray d_ack -> d_req=0 immediately, no writeback, state IDLE.
REQ-039 Back-to-back LW then LBU addr 0x1, d_rdata=0x0000F000 -> second request one IDLE cycle later, wb_result=0x000000F0.
REQ-040 MEM_ALIGN_CHECK_EN, LW addr 0x6 -> d_req stays 0, o_alignErr=1 one cycle, wb_regDest=0; undefined: d_sel=1111, access completes.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one data-bus transaction per load/store,
// stalls upstream until d_ack, and registers the writeback. Optional MEM_ALIGN_CHECK_EN.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_memop,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_regDest,
  output logic        d_req,
  output logic        d_we,
  output logic [29:0] d_addr,
  output logic [3:0]  d_sel,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        o_stall,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_regDest,
  output logic        o_alignErr
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic        misalign, start;
  logic [1:0]  lat_size, lat_off;
  logic        lat_load;
  logic [4:0]  lat_rd;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt, lane, load_val;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = i_memop[2] &&
                    ((i_memop[1:0] == 2'b01 && i_addr[0]) ||
                     (i_memop[1:0] == 2'b10 && i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign start = (state == IDLE) && i_memop[2] && !misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (d_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_stall = start || (state == BUSY && !d_ack);

    case (i_memop[1:0])
      2'b10:   sel_nxt = 4'b1111;
      2'b01:   sel_nxt = i_addr[1] ? 4'b1100 : 4'b0011;
      default: sel_nxt = 4'b0001 << i_addr[1:0];
    endcase

    case (i_memop[1:0])
      2'b10:   wdata_nxt = i_storeData;
      2'b01:   wdata_nxt = {2{i_storeData[15:0]}};
      default: wdata_nxt = {4{i_storeData[7:0]}};
    endcase

    // lat_off is already lane-aligned for the access size, so one shift serves all sizes
    lane = d_rdata >> {lat_off, 3'b000};
    case (lat_size)
      2'b00:   load_val = {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{16{lane[15]}}, lane[15:0]};
      2'b10:   load_val = d_rdata;
      default: load_val = {24'h0, lane[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_req      <= 1'b0;
      d_we       <= 1'b0;
      d_addr     <= '0;
      d_sel      <= '0;
      d_wdata    <= '0;
      wb_result  <= '0;
      wb_regDest <= '0;
      o_alignErr <= 1'b0;
      lat_size   <= '0;
      lat_off    <= '0;
      lat_load   <= 1'b0;
      lat_rd     <= '0;
    end else if (state == IDLE) begin
      o_alignErr <= misalign;
      if (start) begin
        d_req      <= 1'b1;
        d_we       <= ~i_memop[3];
        d_addr     <= i_addr[31:2];
        d_sel      <= sel_nxt;
        d_wdata    <= wdata_nxt;
        lat_size   <= i_memop[1:0];
        lat_off    <= (i_memop[1:0] == 2'b10) ? 2'b00 :
                      (i_memop[1:0] == 2'b01) ? {i_addr[1], 1'b0} : i_addr[1:0];
        lat_load   <= i_memop[3];
        lat_rd     <= i_regDest;
        wb_result  <= '0;
        wb_regDest <= '0;
      end else if (misalign) begin
        wb_result  <= '0;
        wb_regDest <= '0;
      end else begin
        wb_result  <= i_result;
        wb_regDest <= i_regDest;
      end
    end else begin
      o_alignErr <= 1'b0;
      if (d_ack && lat_load) begin
        d_req      <= 1'b0;
        wb_result  <= load_val;
        wb_regDest <= lat_rd;
      end else begin
        if (d_ack) d_req <= 1'b0;
        wb_result  <= '0;
        wb_regDest <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access; reference model works on whole
// transactions with plain arithmetic. Honors MEM_ALIGN_CHECK_EN like the design.
module tb_mem_access;

  logic        clk, rst;
  logic [3:0]  i_memop;
  logic [31:0] i_addr, i_storeData, i_result;
  logic [4:0]  i_regDest;
  logic        d_req, d_we;
  logic [29:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        o_stall;
  logic [31:0] wb_result;
  logic [4:0]  wb_regDest;
  logic        o_alignErr;

  mem_access dut (
    .clk(clk), .rst(rst), .i_memop(i_memop), .i_addr(i_addr),
    .i_storeData(i_storeData), .i_result(i_result), .i_regDest(i_regDest),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .o_stall(o_stall), .wb_result(wb_result),
    .wb_regDest(wb_regDest), .o_alignErr(o_alignErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        chk_res;
    logic        req;
    logic        aerr;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_exp_t;

  wb_exp_t  wq[$];
  bus_exp_t bq[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic        busy = 1'b0, in_rst = 1'b1;
  logic [3:0]  p_memop;
  logic [31:0] p_addr;
  logic [4:0]  p_rd;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd2) ? 4 : (sz == 2'd1) ? 2 : 1;
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd2) return 0;
    if (sz == 2'd1) return (a % 4 >= 2) ? 2 : 0;
    return a % 4;
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (!op[2]) return 1'b0;
    if (op[1:0] == 2'd1) return (a % 2) != 0;
    if (op[1:0] == 2'd2) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_value(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int nb = nbytes(sz);
    logic [31:0] v, mask;
    if (nb == 4) return rdata;
    v    = rdata >> (8 * lane_off(sz, a));
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (sz != 2'd3 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One clock cycle: drive inputs at negedge, predict, check stall, queue expectations.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] res, input logic [4:0] rd,
                      input logic ack, input logic [31:0] rdata);
    wb_exp_t  e;
    bus_exp_t b;
    logic     exp_stall;
    int       nb;
    @(negedge clk);
    rst = !in_rst;
    i_memop = op; i_addr = a; i_storeData = sd; i_result = res; i_regDest = rd;
    d_ack = ack; d_rdata = rdata;
    #1;
    e = '{res: 32'h0, rd: 5'h0, chk_res: 1'b1, req: 1'b0, aerr: 1'b0};
    exp_stall = 1'b0;
    if (in_rst) begin
      busy = 1'b0;
    end else if (!busy) begin
      if (op[2] && misaligned(op, a)) begin
        e.aerr = 1'b1;
      end else if (op[2]) begin
        exp_stall = 1'b1;
        e.req = 1'b1;
        nb = nbytes(op[1:0]);
        b.we    = !op[3];
        b.addr  = a[31:2];
        b.sel   = 4'(((1 << nb) - 1) << lane_off(op[1:0], a));
        b.wdata = (nb == 4) ? sd :
                  (nb == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : (sd & 32'hFF) * 32'h0101_0101;
        bq.push_back(b);
        busy = 1'b1; p_memop = op; p_addr = a; p_rd = rd;
      end else begin
        e.res = res; e.rd = rd;
      end
    end else if (!ack) begin
      exp_stall = 1'b1;
      e.req = 1'b1;
    end else begin
      busy = 1'b0;
      if (p_memop[3]) begin
        e.rd = p_rd;
        e.res = load_value(p_memop[1:0], p_addr, rdata);
        e.chk_res = (p_rd != 5'd0);
      end
    end
    chk("o_stall", {31'h0, o_stall}, {31'h0, exp_stall});
    wq.push_back(e);
  endtask

  // A full memory op: IDLE request cycle, wait cycles (low address bits disturbed), ack cycle.
  task automatic op_mem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input int waits, input logic [31:0] rdata);
    step(op, a, sd, $urandom, rd, 1'b0, $urandom);
    if (!busy) return;
    for (int w = 0; w < waits; w++)
      step(op, a ^ {30'h0, 2'($urandom)}, sd, $urandom, rd, 1'b0, $urandom);
    step(op, a ^ {30'h0, 2'($urandom)}, sd, $urandom, rd, 1'b1, rdata);
  endtask

  // ---------------- monitor ----------------
  bus_exp_t cur;
  logic     prev_req = 1'b0;
  initial begin
    wb_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wb_regDest", {27'h0, wb_regDest}, {27'h0, e.rd});
        if (e.chk_res) chk("wb_result", wb_result, e.res);
        chk("d_req", {31'h0, d_req}, {31'h0, e.req});
        chk("o_alignErr", {31'h0, o_alignErr}, {31'h0, e.aerr});
      end
      if (d_req && !prev_req) begin
        if (bq.size() == 0) chk("bus_req_unexpected", {31'h0, d_req}, 32'h0);
        else cur = bq.pop_front();
      end
      if (d_req) begin
        chk("d_we", {31'h0, d_we}, {31'h0, cur.we});
        chk("d_addr", {2'h0, d_addr}, {2'h0, cur.addr});
        chk("d_sel", {28'h0, d_sel}, {28'h0, cur.sel});
        chk("d_wdata", d_wdata, cur.wdata);
      end
      prev_req = d_req;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] op;
    rst = 1'b0; i_memop = 0; i_addr = 0; i_storeData = 0; i_result = 0; i_regDest = 0;
    d_ack = 0; d_rdata = 0;
    #3;
    chk("rst_d_req", {31'h0, d_req}, 32'h0);
    chk("rst_d_sel", {28'h0, d_sel}, 32'h0);
    chk("rst_d_wdata", d_wdata, 32'h0);
    chk("rst_wb_result", wb_result, 32'h0);
    chk("rst_wb_regDest", {27'h0, wb_regDest}, 32'h0);
    chk("rst_o_alignErr", {31'h0, o_alignErr}, 32'h0);
    step(0, 0, 0, 32'hDEAD, 3, 1'b0, 0);
    in_rst = 1'b0;

    // non-memory op
    step(4'b0000, 0, 0, 32'h12345678, 5'd5, 1'b0, 0);
    // LB 0x103, three wait cycles
    op_mem(4'b1100, 32'h103, 0, 5'd7, 3, 32'h80FF_FFFF);
    // SH 0x202
    op_mem(4'b0101, 32'h202, 32'hABCD, 5'd9, 1, 32'h0);

    // LW 0x10 abandoned by reset mid-access, then a stray ack
    step(4'b1110, 32'h10, 0, 0, 5'd4, 1'b0, 0);
    @(negedge clk);
    in_rst = 1'b1; rst = 1'b0;
    #1;
    chk("async_rst_d_req", {31'h0, d_req}, 32'h0);
    chk("async_rst_wb_regDest", {27'h0, wb_regDest}, 32'h0);
    step(0, 0, 0, 0, 0, 1'b1, 32'h1234);
    in_rst = 1'b0;
    step(0, 0, 0, 32'h5555, 5'd0, 1'b1, 32'h1234);

    // back-to-back LW then LBU 0x1
    op_mem(4'b1110, 32'h8, 0, 5'd2, 0, 32'hCAFE_F00D);
    op_mem(4'b1111, 32'h1, 0, 5'd3, 0, 32'h0000_F000);

    // word at 0x6: rejected with the check enabled, full-word access otherwise
    op_mem(4'b1110, 32'h6, 0, 5'd6, 1, 32'h7654_3210);
    op_mem(4'b1101, 32'h5, 0, 5'd8, 0, 32'h8765_4321);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        step(4'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             5'($urandom), ($urandom_range(0, 3) == 0), $urandom);
      end else begin
        op = {1'($urandom), 1'b1, 2'($urandom)};
        op_mem(op, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
      end
    end
    step(0, 0, 0, 32'h0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);

    chk("wb_queue_drained", wq.size(), 32'h0);
    chk("bus_queue_drained", bq.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
